// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures the high time in ticks, strobes accepted widths or rejected pulses, and flags signal loss.
// Latency: 3 clk input sync, result 1 clk after the synced fall; no backpressure (strobes are fire-and-forget).
module servo_pwm_decoder #(
    parameter int TICK_DIV = 1000,
    parameter int OFFSET   = 50,
    parameter int MAX_HIGH = 400,
    parameter int TIMEOUT  = 2500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [7:0] pwm_width,
    output logic       width_valid,
    output logic       pulse_error,
    output logic       signal_lost
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [8:0]    HC_OFF     = 9'(OFFSET);
    localparam logic [8:0]    HC_LAST    = 9'(MAX_HIGH - 1);
    localparam logic [8:0]    HC_MAX     = 9'(MAX_HIGH);
    localparam logic [TW-1:0] TO_LIM     = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_PRE     = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH
    } state_t;

    logic          r_sync1, r_sync2, r_hist;
    logic [1:0]    r_settle;
    logic [PW-1:0] r_presc;
    state_t        r_state;
    logic [8:0]    r_hcnt;
    logic [TW-1:0] r_tocnt;
    logic [7:0]    r_width;
    logic          r_valid, r_err, r_lost;

    logic          w_rise, w_fall, w_tick, w_to_clr;
    logic [PW-1:0] w_presc_cur;
    logic [8:0]    w_diff;
    state_t        w_state_nxt;
    logic [8:0]    w_hcnt_nxt;
    logic [7:0]    w_width_nxt;
    logic          w_valid_nxt, w_err_nxt;

    assign w_rise   = r_sync2 & ~r_hist;
    assign w_fall   = ~r_sync2 & r_hist;
    // The rise cycle itself counts as prescaler phase 0, so N*TICK_DIV high cycles hold exactly N ticks.
    assign w_presc_cur = w_rise ? '0 : r_presc;
    assign w_tick      = (w_presc_cur == PRESC_LAST);
    assign w_to_clr    = (r_state == WAIT_RISE) && w_rise;
    assign w_diff      = r_hcnt - HC_OFF;

    // r_settle keeps WAIT_LOW from trusting the zeroed synchronizer right after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_hist   <= 1'b0;
            r_settle <= 2'd0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            if (!r_settle[1]) begin
                r_settle <= r_settle + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_tocnt <= '0;
            r_lost  <= 1'b1;
        end else begin
            r_presc <= w_tick ? '0 : w_presc_cur + 1'b1;
            if (w_to_clr) begin
                r_tocnt <= '0;
            end else if (w_tick && (r_tocnt != TO_LIM)) begin
                r_tocnt <= r_tocnt + 1'b1;
            end
            if (w_valid_nxt) begin
                r_lost <= 1'b0;
            end else if (!w_to_clr && w_tick && (r_tocnt == TO_PRE)) begin
                r_lost <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_width_nxt = r_width;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            WAIT_LOW: begin
                if (r_settle[1] && !r_sync2) begin
                    w_state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (w_rise) begin
                    w_hcnt_nxt  = '0;
                    w_state_nxt = HIGH;
                end
            end
            HIGH: begin
                // Fall takes priority so a tick landing on the fall is not counted.
                if (w_fall) begin
                    w_state_nxt = WAIT_RISE;
                    if (r_hcnt < HC_OFF) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_width_nxt = w_diff[8] ? 8'hFF : w_diff[7:0];
                    end
                end else if (w_tick) begin
                    if (r_hcnt == HC_LAST) begin
                        w_hcnt_nxt  = HC_MAX;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = WAIT_LOW;
                    end else begin
                        w_hcnt_nxt = r_hcnt + 9'd1;
                    end
                end
            end
            default: w_state_nxt = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WAIT_LOW;
            r_hcnt  <= '0;
            r_width <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_width <= w_width_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign pwm_width   = r_width;
    assign width_valid = r_valid;
    assign pulse_error = r_err;
    assign signal_lost = r_lost;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder: directed pulses with a per-cycle event-time model plus literal spot checks.
module tb_servo_pwm_decoder;

    localparam int TD   = 4;
    localparam int OFF  = 50;
    localparam int MAXH = 400;
    localparam int TO   = 2500;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       pwm_in = 1'b0;
    logic [7:0] pwm_width;
    logic       width_valid, pulse_error, signal_lost;

    servo_pwm_decoder #(
        .TICK_DIV(TD),
        .OFFSET  (OFF),
        .MAX_HIGH(MAXH),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .pwm_width  (pwm_width),
        .width_valid(width_valid),
        .pulse_error(pulse_error),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc_at;
        bit         is_err;
        logic [7:0] w;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] exp_width;
    bit         exp_lost;
    int         lost_at;
    bit         armed;

    int n_pass = 0, n_total = 0;
    int n_valid_seen = 0, n_err_seen = 0;
    int lost_rise_cyc = -1, lost_fall_cyc = -1, first_valid_cyc = -1, last_err_cyc = -1;
    int last_rise_c = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        evq.delete();
        exp_width = 8'd0;
        exp_lost  = 1'b1;
        lost_at   = -1;
    endtask

    // Expected strobes are scheduled from pulse length: ticks = floor(high_cycles / TD).
    task automatic pulse(input int hi, input int lo);
        int c, n, wv;
        @(negedge clk);
        c = cyc;
        pwm_in = 1'b1;
        last_rise_c = c;
        n = hi / TD;
        if (armed) begin
            lost_at = c + 2 + TO * TD;
            if (n >= MAXH) begin
                evq.push_back('{cyc_at: c + 2 + MAXH * TD, is_err: 1'b1, w: 8'd0});
            end else if (n < OFF) begin
                evq.push_back('{cyc_at: c + hi + 3, is_err: 1'b1, w: 8'd0});
            end else begin
                wv = (n - OFF > 255) ? 255 : n - OFF;
                evq.push_back('{cyc_at: c + hi + 3, is_err: 1'b0, w: 8'(wv)});
            end
        end
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        armed = 1'b1;
        repeat (lo) @(negedge clk);
    endtask

    task automatic compare_loop();
        bit prev_lost = 1'b1;
        forever begin
            bit ev_v, ev_e;
            @(posedge clk);
            #1;
            ev_v = 1'b0;
            ev_e = 1'b0;
            while (evq.size() > 0 && evq[0].cyc_at < cyc) void'(evq.pop_front());
            if (evq.size() > 0 && evq[0].cyc_at == cyc) begin
                if (evq[0].is_err) ev_e = 1'b1;
                else begin
                    ev_v      = 1'b1;
                    exp_width = evq[0].w;
                    exp_lost  = 1'b0;
                end
                void'(evq.pop_front());
            end
            if (cyc == lost_at && !ev_v) exp_lost = 1'b1;
            n_total++;
            if ({pwm_width, width_valid, pulse_error, signal_lost} === {exp_width, ev_v, ev_e, exp_lost})
                n_pass++;
            else
                $display("FAIL outputs cyc=%0d got width=%0d valid=%0b err=%0b lost=%0b expected width=%0d valid=%0b err=%0b lost=%0b",
                         cyc, pwm_width, width_valid, pulse_error, signal_lost, exp_width, ev_v, ev_e, exp_lost);
            if (width_valid) begin
                n_valid_seen++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (pulse_error) begin
                n_err_seen++;
                last_err_cyc = cyc;
            end
            if (signal_lost && !prev_lost) lost_rise_cyc = cyc;
            if (!signal_lost && prev_lost) lost_fall_cyc = cyc;
            prev_lost = signal_lost;
        end
    endtask

    initial begin
        int nv, ne;
        fork
            compare_loop();
        join_none
        model_reset();
        armed = 1'b0;
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_lost", int'(signal_lost), 1);
        chk("reset_width", int'(pwm_width), 0);
        chk("reset_valid", int'(width_valid), 0);
        rst = 1'b1;
        armed = 1'b1;
        repeat (20) @(negedge clk);

        // 1.5 ms high, 20 ms period, three periods
        repeat (3) pulse(150 * TD, 1850 * TD);
        chk("p1500_strobes", n_valid_seen, 3);
        chk("p1500_width", int'(pwm_width), 100);
        chk("lost_falls_at_first_strobe", lost_fall_cyc, first_valid_cyc);
        chk("lost_low_after_valid", int'(signal_lost), 0);

        pulse(100 * TD, 200 * TD);
        chk("w_1000us", int'(pwm_width), 50);
        pulse(255 * TD, 200 * TD);
        chk("w_2550us", int'(pwm_width), 205);
        pulse(320 * TD, 200 * TD);
        chk("w_3200us_sat", int'(pwm_width), 255);

        nv = n_valid_seen;
        ne = n_err_seen;
        pulse(30 * TD, 200 * TD);
        chk("short_err", n_err_seen - ne, 1);
        chk("short_no_valid", n_valid_seen - nv, 0);
        chk("short_keeps_width", int'(pwm_width), 255);

        nv = n_valid_seen;
        ne = n_err_seen;
        pulse(500 * TD, 200 * TD);
        chk("stuck_err", n_err_seen - ne, 1);
        chk("stuck_err_time", last_err_cyc - last_rise_c, 1602);
        chk("stuck_no_valid", n_valid_seen - nv, 0);
        pulse(150 * TD, 200 * TD);
        chk("after_stuck_width", int'(pwm_width), 100);

        pulse(150 * TD, 2600 * TD);
        chk("timeout_lost", int'(signal_lost), 1);
        chk("timeout_delay", lost_rise_cyc - last_rise_c, 10002);
        pulse(120 * TD, 100 * TD);
        chk("lost_cleared", int'(signal_lost), 0);
        chk("w_1200us", int'(pwm_width), 70);

        // reset mid-pulse, released while the input is still high
        @(negedge clk);
        pwm_in = 1'b1;
        lost_at = cyc + 2 + TO * TD;
        nv = n_valid_seen;
        repeat (50 * TD) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (10) @(negedge clk);
        chk("midreset_lost", int'(signal_lost), 1);
        chk("midreset_width", int'(pwm_width), 0);
        rst = 1'b1;
        armed = 1'b0;
        repeat (100 * TD) @(negedge clk);
        pwm_in = 1'b0;
        armed = 1'b1;
        repeat (50 * TD) @(negedge clk);
        chk("partial_pulse_ignored", n_valid_seen - nv, 0);
        pulse(120 * TD, 50 * TD);
        chk("post_reset_width", int'(pwm_width), 70);
        chk("post_reset_lost", int'(signal_lost), 0);

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
